dense_ctrl: RTL and testbench

//   Sequencer for a time-multiplexed dense layer (HID_DIM -> CHAR_NUM, N rows, N_LEN-bit fixed point).

---
 rtl/dense_ctrl_pkg.sv | 23 ++
 rtl/dense_ctrl_delay.sv | 44 ++++
 rtl/dense_ctrl.sv | 169 ++++++++++++++++
 tb/tb_dense_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/dense_ctrl_pkg.sv
// Shared definitions for the dense-layer sequencer: layer-size defaults,
// FSM state type and a width helper.
package dense_ctrl_pkg;

    localparam int unsigned N        = 16;   // rows covered by the MAC array
    localparam int unsigned HID_DIM  = 24;
    localparam int unsigned CHAR_NUM = 200;
    localparam int unsigned N_LEN    = 16;

    typedef enum logic [2:0] {
        DC_IDLE  = 3'd0,
        DC_LOAD  = 3'd1,
        DC_DRAIN = 3'd2,
        DC_WRITE = 3'd3,
        DC_DONE  = 3'd4
    } dc_state_t;

    // Index width that never collapses to zero bits for degenerate sizes.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/dense_ctrl_delay.sv
// Fixed-depth delay line aligning MAC issue flags with weight-ROM read data.
// DEPTH=0 is a combinational bypass; flush clears every stage synchronously.
module dense_ctrl_delay #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned W     = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    if (DEPTH == 0) begin : g_bypass
        logic unused_ctrl;
        always_comb unused_ctrl = ^{clk, rst_n, flush};
        always_comb dout = din;
    end else begin : g_pipe
        logic [W-1:0] pipe_q [DEPTH];
        logic [W-1:0] pipe_d [DEPTH];

        always_comb begin
            pipe_d[0] = flush ? '0 : din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                pipe_d[i] = flush ? '0 : pipe_q[i-1];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    pipe_q[i] <= '0;
                end
            end else begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    pipe_q[i] <= pipe_d[i];
                end
            end
        end

        always_comb dout = pipe_q[DEPTH-1];
    end

endmodule

// File: rtl/dense_ctrl.sv
// Sequencer for a time-multiplexed dense layer: walks PAR-wide output tiles and the
// K_DIM reduction per tile. Optional busy-cycle counter enabled by DENSE_CTRL_PERF_EN.
module dense_ctrl
    import dense_ctrl_pkg::*;
#(
    parameter  int unsigned K_DIM   = HID_DIM,
    parameter  int unsigned OUT_DIM = CHAR_NUM,
    parameter  int unsigned PAR     = 8,
    parameter  int unsigned WLAT    = 1,
    localparam int unsigned NT      = OUT_DIM / PAR,
    localparam int unsigned AW      = clog2_min1(NT * K_DIM),
    localparam int unsigned KW      = clog2_min1(K_DIM),
    localparam int unsigned TW      = clog2_min1(NT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run,
    output logic          valid,
    output logic          busy,
    output logic [AW-1:0] w_addr,
    output logic [KW-1:0] k_idx,
    output logic          acc_en,
    output logic          acc_load,
    output logic          out_we,
    output logic [TW-1:0] out_tile,
    output logic [31:0]   perf_cycles
);

    localparam int unsigned DW         = 3;
    localparam int unsigned DRAIN_LAST = (WLAT == 0) ? 0 : WLAT - 1;

    if (OUT_DIM % PAR != 0) begin : g_chk_par
        $error("dense_ctrl: OUT_DIM must be a multiple of PAR");
    end
    if (WLAT > 4) begin : g_chk_wlat
        $error("dense_ctrl: WLAT must be in 0..4");
    end

    dc_state_t     state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [TW-1:0] tile_q, tile_d;
    logic [DW-1:0] dcnt_q, dcnt_d;

    logic          last_k, last_tile, drain_done, flush;
    logic          issue_en, issue_load;
    logic [KW-1:0] issue_k;
    logic [KW+1:0] dly_out;

    always_comb begin
        last_k     = (k_q == KW'(K_DIM - 1));
        last_tile  = (tile_q == TW'(NT - 1));
        drain_done = (dcnt_q == DW'(DRAIN_LAST));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DC_IDLE;
            k_q     <= '0;
            tile_q  <= '0;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            tile_q  <= tile_d;
            dcnt_q  <= dcnt_d;
        end
    end

    // Dropping run in any busy state aborts straight to IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            DC_IDLE: begin
                if (run) state_d = DC_LOAD;
            end
            DC_LOAD: begin
                if (!run)        state_d = DC_IDLE;
                else if (last_k) state_d = (WLAT == 0) ? DC_WRITE : DC_DRAIN;
            end
            DC_DRAIN: begin
                if (!run)            state_d = DC_IDLE;
                else if (drain_done) state_d = DC_WRITE;
            end
            DC_WRITE: begin
                if (!run)           state_d = DC_IDLE;
                else if (last_tile) state_d = DC_DONE;
                else                state_d = DC_LOAD;
            end
            DC_DONE: begin
                if (!run) state_d = DC_IDLE;
            end
            default: state_d = DC_IDLE;
        endcase
    end

    // k and tile saturate at their last value; both clear whenever IDLE is re-entered.
    always_comb begin
        k_d    = k_q;
        tile_d = tile_q;
        dcnt_d = '0;
        if (state_d == DC_IDLE) begin
            k_d    = '0;
            tile_d = '0;
        end else begin
            if (state_q == DC_LOAD && !last_k) begin
                k_d = k_q + 1'b1;
            end
            if (state_q == DC_DRAIN) begin
                dcnt_d = dcnt_q + 1'b1;
            end
            if (state_q == DC_WRITE && state_d == DC_LOAD) begin
                k_d    = '0;
                tile_d = tile_q + 1'b1;
            end
        end
    end

    always_comb begin
        busy       = (state_q == DC_LOAD) || (state_q == DC_DRAIN) || (state_q == DC_WRITE);
        valid      = (state_q == DC_DONE);
        out_we     = (state_q == DC_WRITE);
        out_tile   = tile_q;
        w_addr     = AW'(32'(tile_q) * K_DIM + 32'(k_q));
        issue_en   = (state_q == DC_LOAD);
        issue_load = issue_en && (k_q == '0);
        issue_k    = issue_en ? k_q : '0;
        flush      = (state_d == DC_IDLE);
    end

    dense_ctrl_delay #(
        .DEPTH(WLAT),
        .W    (KW + 2)
    ) u_delay (
        .clk  (clk),
        .rst_n(rst_n),
        .flush(flush),
        .din  ({issue_en, issue_load, issue_k}),
        .dout (dly_out)
    );

    always_comb begin
        acc_en   = dly_out[KW+1];
        acc_load = dly_out[KW];
        k_idx    = dly_out[KW-1:0];
    end

`ifdef DENSE_CTRL_PERF_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (state_q == DC_IDLE && state_d == DC_LOAD) begin
            perf_d = '0;
        end else if (busy && perf_q != '1) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) perf_q <= '0;
        else        perf_q <= perf_d;
    end

    always_comb perf_cycles = perf_q;
`else
    always_comb perf_cycles = '0;
`endif

endmodule

// File: tb/tb_dense_ctrl.sv
// Scoreboard bench for dense_ctrl: three instances (WLAT 0, 1, 3) share clock, reset and run.
`timescale 1ns/1ps
module tb_dense_ctrl;

    localparam int unsigned K   = 24;
    localparam int unsigned OD  = 200;
    localparam int unsigned P   = 8;
    localparam int unsigned NT  = OD / P;
    localparam int unsigned ND  = 3;
    localparam int unsigned AW  = 10;
    localparam int unsigned KW  = 5;
    localparam int unsigned TW  = 5;
    localparam int          ACC = 1 << 24;
    localparam int          WR  = 2 << 24;
    localparam int          VLD = 3 << 24;

    logic clk = 1'b0;
    logic rst_n;
    logic run;
    always #5 clk = ~clk;

    logic          valid_w    [ND];
    logic          busy_w     [ND];
    logic          acc_en_w   [ND];
    logic          acc_load_w [ND];
    logic          out_we_w   [ND];
    logic [AW-1:0] w_addr_w   [ND];
    logic [KW-1:0] k_idx_w    [ND];
    logic [TW-1:0] out_tile_w [ND];
    logic [31:0]   perf_w     [ND];

    function automatic int unsigned wl_of(input int unsigned i);
        return (i == 0) ? 0 : (i == 1) ? 1 : 3;
    endfunction

    for (genvar g = 0; g < ND; g++) begin : g_dut
        localparam int unsigned WL = (g == 0) ? 0 : (g == 1) ? 1 : 3;
        dense_ctrl #(.K_DIM(K), .OUT_DIM(OD), .PAR(P), .WLAT(WL)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .run        (run),
            .valid      (valid_w[g]),
            .busy       (busy_w[g]),
            .w_addr     (w_addr_w[g]),
            .k_idx      (k_idx_w[g]),
            .acc_en     (acc_en_w[g]),
            .acc_load   (acc_load_w[g]),
            .out_we     (out_we_w[g]),
            .out_tile   (out_tile_w[g]),
            .perf_cycles(perf_w[g])
        );
    end

    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned edge_cnt = 0;
    int          exp_q [ND][$];
    int unsigned hist  [ND][8];
    logic        valid_prev [ND];
    logic        run_prev;
    bit          quiet;
    bit          final_req;
    bit          final_done;

    initial forever begin
        @(posedge clk);
        edge_cnt++;
    end

    task automatic chk(input bit ok, input string nm, input int unsigned d,
                       input longint unsigned act, input longint unsigned req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s dut%0d(WLAT=%0d) t=%0t actual=0x%0h required=0x%0h",
                     nm, d, wl_of(d), $time, act, req);
        end
    endtask

    function automatic int pop_exp(input int unsigned i);
        if (exp_q[i].size() == 0) return -1;
        return exp_q[i].pop_front();
    endfunction

    // Monitor: samples mid-cycle and retires expected events in order.
    initial begin
        for (int unsigned i = 0; i < ND; i++) valid_prev[i] = 1'b0;
        run_prev = 1'b0;
        forever begin
            @(negedge clk);
            for (int unsigned i = 0; i < ND; i++) begin
                int unsigned wl, src, ek, exp_perf;
                int          got;
                wl  = wl_of(i);
                src = (wl == 0) ? 32'(w_addr_w[i]) : hist[i][(edge_cnt + 8 - wl) % 8];
                hist[i][edge_cnt % 8] = 32'(w_addr_w[i]);

                chk(!(valid_w[i] && busy_w[i]), "valid_busy_excl", i,
                    {valid_w[i], busy_w[i]}, 0);
                chk(!(acc_en_w[i] && out_we_w[i]), "acc_we_excl", i,
                    {acc_en_w[i], out_we_w[i]}, 0);

                if (acc_en_w[i]) begin
                    got = pop_exp(i);
                    chk(got == (ACC | int'(src)), "acc_w_addr", i, src, got & 32'hFF_FFFF);
                    ek = (got & 32'hFF_FFFF) % K;
                    chk(32'(k_idx_w[i]) == ek, "k_idx", i, k_idx_w[i], ek);
                    chk(acc_load_w[i] == (ek == 0), "acc_load", i, acc_load_w[i], ek == 0);
                end
                if (out_we_w[i]) begin
                    got = pop_exp(i);
                    chk(got == (WR | int'(out_tile_w[i])), "out_tile", i,
                        out_tile_w[i], got & 32'hFF_FFFF);
                end
                if (valid_w[i] && !valid_prev[i]) begin
                    got = pop_exp(i);
                    chk(got == (VLD | int'(edge_cnt)), "valid_edge", i,
                        edge_cnt, got & 32'hFF_FFFF);
`ifdef DENSE_CTRL_PERF_EN
                    exp_perf = NT * (K + wl + 1);
`else
                    exp_perf = 0;
`endif
                    chk(perf_w[i] == exp_perf, "perf_at_valid", i, perf_w[i], exp_perf);
                end
                if (valid_prev[i] && rst_n) begin
                    chk(valid_w[i] == run_prev, "valid_hold_drop", i, valid_w[i], run_prev);
                end
`ifndef DENSE_CTRL_PERF_EN
                chk(perf_w[i] == 0, "perf_tied_zero", i, perf_w[i], 0);
`endif
                if (quiet) begin
                    chk({valid_w[i], busy_w[i], acc_en_w[i], acc_load_w[i], out_we_w[i],
                         w_addr_w[i], k_idx_w[i], out_tile_w[i]} == '0, "idle_outputs", i,
                        {valid_w[i], busy_w[i], acc_en_w[i], acc_load_w[i], out_we_w[i],
                         w_addr_w[i], k_idx_w[i], out_tile_w[i]}, 0);
                end
                valid_prev[i] = valid_w[i];
            end
            run_prev = run;
            if (final_req && !final_done) begin
                for (int unsigned i = 0; i < ND; i++) begin
                    chk(exp_q[i].size() == 0, "events_outstanding", i, exp_q[i].size(), 0);
                end
                final_done = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: every tile issues k=0..K-1 at tile*K+k, then one write; valid
    // appears NT*(K+WLAT+1) edges after the edge that samples run.
    task automatic push_job();
        for (int unsigned i = 0; i < ND; i++) begin
            for (int unsigned t = 0; t < NT; t++) begin
                for (int unsigned k = 0; k < K; k++) exp_q[i].push_back(ACC | int'(t * K + k));
                exp_q[i].push_back(WR | int'(t));
            end
            exp_q[i].push_back(VLD | int'(edge_cnt + 1 + NT * (K + wl_of(i) + 1)));
        end
    endtask

    task automatic clear_exp();
        for (int unsigned i = 0; i < ND; i++) exp_q[i].delete();
    endtask

    task automatic job_normal();
        int unsigned n;
        push_job();
        quiet = 1'b0;
        run   = 1'b1;
        n = 0;
        while (!(valid_w[0] && valid_w[1] && valid_w[2]) && n < 1000) begin
            tick();
            n++;
        end
        repeat (100) tick();
        run = 1'b0;
        tick();
        quiet = 1'b1;
        repeat ($urandom_range(2, 8)) tick();
    endtask

    task automatic job_abort();
        int unsigned e0, off;
        push_job();
        quiet = 1'b0;
        run   = 1'b1;
        e0    = edge_cnt;
        off   = 1 + 7 * (K + 2) + $urandom_range(0, K + 1);
        while (edge_cnt < e0 + off) tick();
        run = 1'b0;
        tick();
        clear_exp();
        quiet = 1'b1;
        repeat ($urandom_range(3, 10)) tick();
    endtask

    task automatic job_reset();
        push_job();
        quiet = 1'b0;
        run   = 1'b1;
        repeat ($urandom_range(30, 400)) tick();
        #2 rst_n = 1'b0;
        #1;
        clear_exp();
        quiet = 1'b1;
        run   = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat ($urandom_range(2, 6)) tick();
    endtask

    initial begin
        rst_n      = 1'b0;
        run        = 1'b0;
        quiet      = 1'b1;
        final_req  = 1'b0;
        final_done = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) tick();
        job_normal();
        job_abort();
        job_normal();
        job_reset();
        job_normal();
        final_req = 1'b1;
        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
